// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the single-cycle MIPS datapath: register-file
// geometry, the hardwired-zero register index and the common word/address
// typedefs used by regfile and its debug tap.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam int WR_CNT_W = 16;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : mips_pkg

// File: rtl/regfile_dbg_tap.sv
// -----------------------------------------------------------------------------
// regfile_dbg_tap
// Records every committed register-file write: a one-cycle valid pulse, the
// address and data of the most recent commit, and a saturating commit count.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   commit_i     in   a write is being committed at this edge
//   waddr_i      in   address of the write being committed
//   wdata_i      in   data of the write being committed
//   dbg_valid_o  out  high for the cycle following each commit
//   dbg_waddr_o  out  address of the last commit (held between commits)
//   dbg_wdata_o  out  data of the last commit (held between commits)
//   wr_count_o   out  number of commits, saturating at all-ones
// -----------------------------------------------------------------------------
module regfile_dbg_tap
    import mips_pkg::*;
#(
    parameter int DW = REG_DW,
    parameter int AW = REG_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                commit_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [DW-1:0]       wdata_i,
    output logic                dbg_valid_o,
    output logic [AW-1:0]       dbg_waddr_o,
    output logic [DW-1:0]       dbg_wdata_o,
    output logic [WR_CNT_W-1:0] wr_count_o
);

    logic                valid_q, valid_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [WR_CNT_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        valid_d = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        if (commit_i) begin
            valid_d = 1'b1;
            waddr_d = waddr_i;
            wdata_d = wdata_i;
            // Saturate instead of wrapping so a long run never looks idle.
            if (count_q != '1) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
        end
    end

    assign dbg_valid_o = valid_q;
    assign dbg_waddr_o = waddr_q;
    assign dbg_wdata_o = wdata_q;
    assign wr_count_o  = count_q;

endmodule : regfile_dbg_tap

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
// 2^AW x DW general-purpose register file for the single-cycle MIPS
// datapath. Two combinational read ports, one write port written on the
// rising edge. Register 0 is hardwired to zero: writes to it are dropped and
// neither stored nor counted. A debug tap reports every committed write.
//
// Build option: define REGFILE_BYPASS_EN to forward a committing write's data
// to a read port addressing the same register in the same cycle. Left
// undefined (the default), reads always return stored contents.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset (clears all registers)
//   ra1 / rd1  in/out  read port 1 address / data (rs)
//   ra2 / rd2  in/out  read port 2 address / data (rt)
//   we         in   write enable (RegWrite)
//   wa         in   write address
//   wd         in   write data
//   dbg_valid  out  pulses the cycle after a committed write
//   dbg_waddr  out  address of the last committed write
//   dbg_wdata  out  data of the last committed write
//   wr_count   out  saturating count of committed writes
// -----------------------------------------------------------------------------
module regfile
    import mips_pkg::*;
#(
    parameter int DW = REG_DW,
    parameter int AW = REG_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       ra1,
    output logic [DW-1:0]       rd1,
    input  logic [AW-1:0]       ra2,
    output logic [DW-1:0]       rd2,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [DW-1:0]       wd,
    output logic                dbg_valid,
    output logic [AW-1:0]       dbg_waddr,
    output logic [DW-1:0]       dbg_wdata,
    output logic [WR_CNT_W-1:0] wr_count
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [DW-1:0] mem_q [DEPTH];
    logic          commit;

    // Writes to register 0 are not commits: nothing stored, nothing counted.
    assign commit = we && (wa != ZERO_ADDR);

    // NOTE: the storage is a flop array, not a RAM macro, so it can and must
    // be cleared by the asynchronous reset like any other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit) begin
            mem_q[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = (ra1 == ZERO_ADDR) ? '0 : mem_q[ra1];
        rd2 = (ra2 == ZERO_ADDR) ? '0 : mem_q[ra2];
`ifdef REGFILE_BYPASS_EN
        // commit already excludes address 0, so $0 keeps reading zero.
        if (commit && (ra1 == wa)) rd1 = wd;
        if (commit && (ra2 == wa)) rd2 = wd;
`endif
    end

    regfile_dbg_tap #(
        .DW (DW),
        .AW (AW)
    ) u_dbg_tap (
        .clk         (clk),
        .rst         (rst),
        .commit_i    (commit),
        .waddr_i     (wa),
        .wdata_i     (wd),
        .dbg_valid_o (dbg_valid),
        .dbg_waddr_o (dbg_waddr),
        .dbg_wdata_o (dbg_wdata),
        .wr_count_o  (wr_count)
    );

endmodule : regfile

// File: tb/tb_regfile.sv
// -----------------------------------------------------------------------------
// tb_regfile
// Self-checking bench for regfile. A behavioural model (array of words,
// integer commit counter, last-commit record) predicts read data and debug
// outputs; directed cases cover reset, write/readback, $0 protection,
// same-cycle read of the write address, reset priority and counter
// saturation, with randomized traffic in between.
// -----------------------------------------------------------------------------
module tb_regfile;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] rd1, rd2, wd;
    logic        we;
    logic        dbg_valid;
    logic [4:0]  dbg_waddr;
    logic [31:0] dbg_wdata;
    logic [15:0] wr_count;

    regfile dut (
        .clk       (clk),
        .rst       (rst),
        .ra1       (ra1),
        .rd1       (rd1),
        .ra2       (ra2),
        .rd2       (rd2),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .dbg_valid (dbg_valid),
        .dbg_waddr (dbg_waddr),
        .dbg_wdata (dbg_wdata),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [31:0] ref_mem [32];
    logic        ref_valid;
    logic [4:0]  ref_waddr;
    logic [31:0] ref_wdata;
    int          ref_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
        ref_valid = 1'b0;
        ref_waddr = 5'd0;
        ref_wdata = 32'h0;
        ref_count = 0;
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic w,
                                             input logic [4:0] wadr, input logic [31:0] d);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (w && wadr != 5'd0 && a == wadr) return d;
`endif
        return ref_mem[a];
    endfunction

    // One clock cycle: drive on the falling edge, check the combinational
    // reads before the rising edge, advance the model at the rising edge,
    // then check the registered debug outputs just after it.
    task automatic cycle(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
        #1;
        check("rd1", rd1, ref_read(r1, w, a, d));
        check("rd2", rd2, ref_read(r2, w, a, d));
        @(posedge clk);
        if (w && a != 5'd0) begin
            ref_mem[a] = d;
            ref_valid  = 1'b1;
            ref_waddr  = a;
            ref_wdata  = d;
            if (ref_count < 65535) ref_count++;
        end else begin
            ref_valid = 1'b0;
        end
        #1;
        check("dbg_valid", 32'(dbg_valid), 32'(ref_valid));
        check("dbg_waddr", 32'(dbg_waddr), 32'(ref_waddr));
        check("dbg_wdata", dbg_wdata, ref_wdata);
        check("wr_count", 32'(wr_count), 32'(ref_count));
    endtask

    task automatic random_cycle();
        cycle(1'($urandom_range(1, 0)), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
    endtask

    initial begin
        // Power-on reset.
        rst = 1'b1; we = 1'b0; wa = 5'd0; wd = 32'h0; ra1 = 5'd5; ra2 = 5'd9;
        ref_reset();
        #2;
        check("por_count", 32'(wr_count), 32'h0);
        check("por_valid", 32'(dbg_valid), 32'h0);
        check("por_rd1", rd1, 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Write/readback at address 5.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        check("wb_count", 32'(wr_count), 32'd1);
        check("wb_waddr", 32'(dbg_waddr), 32'd5);
        cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        check("wb_rd1", rd1, 32'hDEADBEEF);
        check("wb_valid_drop", 32'(dbg_valid), 32'h0);

        // $0 protection.
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
        check("zero_rd1", rd1, 32'h0);
        check("zero_count", 32'(wr_count), 32'd1);

        // Same-cycle read of the write address (old value AAAA).
        cycle(1'b1, 5'd7, 32'h0000AAAA, 5'd0, 5'd0);
        cycle(1'b1, 5'd7, 32'h00001234, 5'd7, 5'd7);
        cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
        check("same_after", rd1, 32'h00001234);

        // Back-to-back commits followed by random traffic.
        for (int i = 1; i < 6; i++) cycle(1'b1, 5'(i + 10), $urandom, 5'(i + 9), 5'(i + 10));
        for (int i = 0; i < 2000; i++) random_cycle();

        // Mid-simulation asynchronous reset: clears everything without an edge.
        @(negedge clk);
        we = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_count", 32'(wr_count), 32'h0);
        check("rst_valid", 32'(dbg_valid), 32'h0);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            #1;
            check("rst_rd1", rd1, 32'h0);
            check("rst_rd2", rd2, 32'h0);
        end
        ref_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) random_cycle();

        // Reset coinciding with a write: the write is discarded.
        @(negedge clk);
        rst = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'h55;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0; we = 1'b0; ra1 = 5'd3;
        ref_reset();
        #1;
        check("rstw_mem3", rd1, 32'h0);
        check("rstw_count", 32'(wr_count), 32'h0);
        cycle(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);

        // Fill the counter to FFFE, then three commits must all read FFFF.
        while (ref_count < 65534)
            cycle(1'b1, 5'($urandom_range(31, 1)), $urandom, 5'($urandom), 5'($urandom));
        check("sat_pre", 32'(wr_count), 32'h0000FFFE);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 5'($urandom_range(31, 1)), $urandom, 5'($urandom), 5'($urandom));
            check("sat", 32'(wr_count), 32'h0000FFFF);
        end
        cycle(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        check("sat_hold", 32'(wr_count), 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile
